// File: rtl/bit_serializer_pkg.sv
// Shared constants for the bit serializer: default word width, counter sizing
// and the two shifter states.
package bit_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Counter has to hold 0..WIDTH inclusive.
    localparam int CNT_W = $clog2(DEFAULT_WIDTH + 1);

    // Shifter states: IDLE while the counter is zero, SHIFT while bits remain.
    localparam logic S_IDLE  = 1'b0;
    localparam logic S_SHIFT = 1'b1;

    // Counter width for an arbitrary word width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-entry valid/ready holding register. Accepts a word when empty and
// releases it when the consumer takes it.
module word_hold_reg
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_take,
    output logic [WIDTH-1:0] out_data
);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Ready depends only on the registered occupancy flag.
    assign in_ready  = ~full_q;
    assign out_valid = full_q;
    assign out_data  = data_q;

    // Next occupancy/data: a take empties the entry, a write fills it.
    // Take only happens when full and a write only when empty, so they never collide.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (out_take) begin
            full_d = 1'b0;
        end
        if (in_valid && !full_q) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    // Storage registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a valid/ready word input and a one-word
// holding buffer so consecutive words stream without idle bits between them.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             state_q;
    logic             state_d;
    logic             dout_q;
    logic             dout_d;

    logic [WIDTH-1:0] sr_shift;
    logic             first_bit_d;
    logic             load_point;
    logic             accept;
    logic             hold_in_ready;
    logic             hold_in_valid;
    logic             hold_full;
    logic             hold_take;
    logic [WIDTH-1:0] hold_data;

    // Shift direction and the bit that will be presented next. The shifter
    // rotates rather than zero-fills: bits beyond the counter are never emitted.
    if (MSB_FIRST) begin : g_msb_first
        assign sr_shift    = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
        assign first_bit_d = sr_d[WIDTH-1];
    end else begin : g_lsb_first
        assign sr_shift    = {sr_q[0], sr_q[WIDTH-1:1]};
        assign first_bit_d = sr_d[0];
    end

    // A load point is an idle edge or the edge on which the last bit leaves.
    assign load_point = (cnt_q == '0) || (cnt_q == CNT_ONE);
    assign din_ready  = hold_in_ready;
    assign accept     = din_valid & din_ready;

    // At a load point with the buffer empty the word bypasses the buffer
    // and goes straight into the shifter, so the buffer only fills mid-word.
    assign hold_in_valid = din_valid & ~load_point;
    assign hold_take     = load_point & hold_full;

    word_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .in_valid (hold_in_valid),
        .in_ready (hold_in_ready),
        .in_data  (din),
        .out_valid(hold_full),
        .out_take (hold_take),
        .out_data (hold_data)
    );

    // State register: shifter, counter, state and the registered serial output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
            dout_q  <= IDLE_BIT;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state logic: reload from buffer or input at a load point, else shift.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_point) begin
            if (hold_full) begin
                sr_d  = hold_data;
                cnt_d = CNT_FULL;
            end else if (accept) begin
                sr_d  = din;
                cnt_d = CNT_FULL;
            end else begin
                sr_d  = '0;
                cnt_d = '0;
            end
        end else begin
            sr_d  = sr_shift;
            cnt_d = cnt_q - CNT_ONE;
        end
        state_d = (cnt_d != '0) ? S_SHIFT : S_IDLE;
    end

    // Output logic: compute next serial bit so dout comes straight from a flop.
    always_comb begin
        dout_d = (state_d == S_SHIFT) ? first_bit_d : IDLE_BIT;
    end

    assign dout       = dout_q;
    assign dout_valid = (state_q == S_SHIFT);
    assign busy       = (state_q == S_SHIFT) | hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances driven in
// parallel, vector table, hand-written corner sequences, a behavioural
// bit-queue reference model and a 1010 detector model on the serial stream.
module tb_bit_serializer;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic [1:0] din_ready;
    logic [1:0] dout;
    logic [1:0] dout_valid;
    logic [1:0] busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .reset(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready[0]), .dout(dout[0]), .dout_valid(dout_valid[0]), .busy(busy[0])
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .reset(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready[1]), .dout(dout[1]), .dout_valid(dout_valid[1]), .busy(busy[1])
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted word appends its bits, in send order, to
    // a queue; each edge one bit is popped and becomes the visible output.
    // The block can accept while less than a full word is still waiting.
    for (genvar gi = 0; gi < 2; gi++) begin : g_model
        bit q[$];
        bit shown_valid = 1'b0;
        bit shown_bit = 1'b0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                q.delete();
                shown_valid = 1'b0;
                shown_bit = 1'b0;
            end else begin
                if (din_valid && (q.size() < W)) begin
                    for (int i = 0; i < W; i++) begin
                        q.push_back((gi == 0) ? din[W-1-i] : din[i]);
                    end
                end
                if (q.size() > 0) begin
                    shown_bit = q.pop_front();
                    shown_valid = 1'b1;
                end else begin
                    shown_valid = 1'b0;
                end
            end
        end

        always @(negedge clk) begin
            check_bit($sformatf("model%0d_dout_valid", gi), dout_valid[gi], shown_valid);
            check_bit($sformatf("model%0d_dout", gi), dout[gi], shown_valid ? shown_bit : 1'b0);
            check_bit($sformatf("model%0d_din_ready", gi), din_ready[gi], q.size() < W);
            check_bit($sformatf("model%0d_busy", gi), busy[gi], shown_valid);
        end
    end

    // Overlapping 1010 detector watching the MSB-first stream every cycle.
    logic [3:0] det_sr = 4'b0000;
    int det_hits = 0;
    always @(negedge clk) begin
        det_sr = {det_sr[2:0], dout[0]};
        if (det_sr == 4'b1010) det_hits++;
    end

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [7:0] w);
        din = w;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cap;
        logic [7:0]  em;
        logic [7:0]  el;
        logic [7:0]  b_word;
        int stall;
        bit got;
        int h0;

        // Stream columns hold bits in emission order, first bit in bit 7.
        vecs[0] = '{word: 8'hA5, exp_msb: 8'hA5, exp_lsb: 8'hA5};
        vecs[1] = '{word: 8'h01, exp_msb: 8'h01, exp_lsb: 8'h80};
        vecs[2] = '{word: 8'h80, exp_msb: 8'h80, exp_lsb: 8'h01};
        vecs[3] = '{word: 8'hC4, exp_msb: 8'hC4, exp_lsb: 8'h23};
        vecs[4] = '{word: 8'h0F, exp_msb: 8'h0F, exp_lsb: 8'hF0};
        vecs[5] = '{word: 8'hFF, exp_msb: 8'hFF, exp_lsb: 8'hFF};

        // Reset state
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_bit($sformatf("reset_dout%0d", k), dout[k], 1'b0);
            check_bit($sformatf("reset_dout_valid%0d", k), dout_valid[k], 1'b0);
            check_bit($sformatf("reset_busy%0d", k), busy[k], 1'b0);
            check_bit($sformatf("reset_din_ready%0d", k), din_ready[k], 1'b1);
        end
        #1 rst = 1'b0;
        $display("reset released");

        // Single words from idle: 8 valid bits in order, then idle
        for (int v = 0; v < 6; v++) begin
            em = vecs[v].exp_msb;
            el = vecs[v].exp_lsb;
            send_one(vecs[v].word);
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                check_bit($sformatf("vec%0d_valid_b%0d", v, k), dout_valid[0] & dout_valid[1], 1'b1);
                check_bit($sformatf("vec%0d_msb_b%0d", v, k), dout[0], em[7-k]);
                check_bit($sformatf("vec%0d_lsb_b%0d", v, k), dout[1], el[7-k]);
            end
            @(negedge clk);
            check_bit($sformatf("vec%0d_idle_valid", v), dout_valid[0] | dout_valid[1], 1'b0);
            check_bit($sformatf("vec%0d_idle_dout", v), dout[0] | dout[1], 1'b0);
            check_bit($sformatf("vec%0d_idle_busy", v), busy[0] | busy[1], 1'b0);
            $display("vector %0d word=%h msb=%h lsb=%h", v, vecs[v].word, em, el);
        end

        // Back-to-back AA then 0F: 16 contiguous bits
        cap = '0;
        din = 8'hAA;
        din_valid = 1'b1;
        step();
        din = 8'h0F;
        @(negedge clk);
        check_bit("b2b_first_valid", dout_valid[0], 1'b1);
        cap = {cap[14:0], dout[0]};
        step();
        din_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 0) check_bit("b2b_ready_low_hold_full", din_ready[0], 1'b0);
            check_bit($sformatf("b2b_valid_b%0d", k + 1), dout_valid[0], 1'b1);
            cap = {cap[14:0], dout[0]};
        end
        check_val("b2b_stream", cap, 16'hAA0F);
        @(negedge clk);
        check_bit("b2b_idle_after", dout_valid[0], 1'b0);
        $display("back-to-back stream=%h", cap);

        // Async reset after 3 bits of FF with a word held
        din = 8'hFF;
        din_valid = 1'b1;
        step();
        din = 8'h33;
        step();
        din_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_bit("rst_mid_dout_valid", dout_valid[0], 1'b0);
        check_bit("rst_mid_din_ready", din_ready[0], 1'b1);
        check_bit("rst_mid_busy", busy[0], 1'b0);
        check_bit("rst_mid_dout", dout[0], 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        cap = '0;
        send_one(8'h80);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_bit($sformatf("post_rst_valid_b%0d", k), dout_valid[0], 1'b1);
            cap = {cap[14:0], dout[0]};
        end
        check_val("post_rst_stream", cap, 16'h0080);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_bit($sformatf("post_rst_idle%0d", k), dout_valid[0], 1'b0);
        end
        $display("mid-word reset then word 80 stream=%h", cap[7:0]);

        // din_valid held while the buffer is full: accepted once
        b_word = 8'hC3;
        din = 8'h5A;
        din_valid = 1'b1;
        step();
        din = b_word;
        step();
        din = 8'h96;
        stall = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (din_ready[0]) got = 1'b1;
            else stall++;
        end
        check_bit("stall_ready_rose", got, 1'b1);
        check_val("stall_cycles", 16'(stall), 16'd7);
        step();
        din_valid = 1'b0;
        cap = '0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check_bit($sformatf("stall_valid_b%0d", k), dout_valid[0], 1'b1);
            cap = {cap[14:0], dout[0]};
        end
        check_val("stall_stream", cap, {1'b0, b_word[6:0], 8'h96});
        @(negedge clk);
        check_bit("stall_single_emit", dout_valid[0], 1'b0);
        $display("stalled word stall=%0d tail=%h", stall, cap);

        // 1010 detector on AA: three overlapping hits, none from idle zeros
        repeat (2) @(negedge clk);
        #1 h0 = det_hits;
        send_one(8'hAA);
        repeat (12) @(negedge clk);
        #1 check_val("detector_hits_AA", 16'(det_hits - h0), 16'd3);
        h0 = det_hits;
        repeat (8) @(negedge clk);
        #1 check_val("detector_hits_idle", 16'(det_hits - h0), 16'd0);
        $display("detector hits on AA checked");

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            din = 8'($urandom);
            case ((c / 500) % 3)
                0: din_valid = ($urandom_range(0, 1) == 1);
                1: din_valid = 1'b1;
                default: din_valid = ($urandom_range(0, 7) == 0);
            endcase
            if (c == 1700) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        repeat (24) step();
        check_bit("random_drained", dout_valid[0] | dout_valid[1] | busy[0] | busy[1], 1'b0);
        $display("random traffic done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
